// File: rtl/gomoku_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gomoku_pkg : command codes, cell encodings, scan states, direction table   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gomoku_pkg;

    localparam logic [2:0] c_cmd_up       = 3'd0;
    localparam logic [2:0] c_cmd_down     = 3'd1;
    localparam logic [2:0] c_cmd_left     = 3'd2;
    localparam logic [2:0] c_cmd_right    = 3'd3;
    localparam logic [2:0] c_cmd_place    = 3'd4;
    localparam logic [2:0] c_cmd_new_game = 3'd5;

    localparam logic [1:0] c_cell_empty = 2'b00;
    localparam logic [1:0] c_cell_black = 2'b01;
    localparam logic [1:0] c_cell_white = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FWD  = 3'd1,
        ST_BWD  = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } scan_state_t;

    // Steps are two's complement: 01 = +1, 11 = -1, 00 = 0
    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } dir_t;

    function automatic dir_t dir_step(input logic [1:0] d);
        dir_t s;
        case (d)
            2'd0:    s = '{dx: 2'b01, dy: 2'b00};
            2'd1:    s = '{dx: 2'b00, dy: 2'b01};
            2'd2:    s = '{dx: 2'b01, dy: 2'b01};
            default: s = '{dx: 2'b01, dy: 2'b11};
        endcase
        return s;
    endfunction

    function automatic logic [1:0] color_cell(input logic color);
        return color ? c_cell_white : c_cell_black;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gomoku_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gomoku_if : command handshake between a controller and gomoku_core         |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface gomoku_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/gomoku_win_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gomoku_win_scan : walks the four lines through the last stone for a win    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gomoku_win_scan
    import gomoku_pkg::*;
#(
    parameter int BOARD_N = 15,
    parameter int WIN_LEN = 5,
    parameter int COORD_W = 4
) (
    input  logic               clk_50MHz,
    input  logic               res_n,
    input  logic               start,
    input  logic [COORD_W-1:0] start_x,
    input  logic [COORD_W-1:0] start_y,
    input  logic               start_color,
    output logic [COORD_W-1:0] probe_x,
    output logic [COORD_W-1:0] probe_y,
    input  logic [1:0]         probe_cell,
    output logic               busy,
    output logic               done,
    output logic               win,
    output logic               win_color
);

    localparam int                 c_cw   = $clog2(WIN_LEN + 1);
    localparam logic [COORD_W-1:0] c_last = COORD_W'(BOARD_N - 1);
    localparam logic [COORD_W-1:0] c_one  = COORD_W'(1);
    localparam logic [c_cw-1:0]    c_win  = c_cw'(WIN_LEN);
    localparam logic [c_cw-1:0]    c_inc  = c_cw'(1);

    scan_state_t        r_state, w_state;
    logic [1:0]         r_dir, w_dir;
    logic [COORD_W-1:0] r_px, r_py, r_cx, r_cy, w_cx, w_cy;
    logic               r_color;
    logic [c_cw-1:0]    r_count, w_count;
    logic               r_win, w_win;
    dir_t               w_step;
    logic [1:0]         w_sx, w_sy;
    logic               w_x_ok, w_y_ok, w_match;
    logic [COORD_W-1:0] w_nx, w_ny;

    // Neighbour in the walk direction; bounds are checked before stepping
    always_comb begin
        w_step = dir_step(r_dir);
        w_sx   = (r_state == ST_BWD) ? 2'(~w_step.dx + 2'd1) : w_step.dx;
        w_sy   = (r_state == ST_BWD) ? 2'(~w_step.dy + 2'd1) : w_step.dy;
        w_x_ok = 1'b1;
        w_nx   = r_cx;
        w_y_ok = 1'b1;
        w_ny   = r_cy;
        if (w_sx == 2'b01) begin
            w_x_ok = (r_cx < c_last);
            w_nx   = r_cx + c_one;
        end else if (w_sx == 2'b11) begin
            w_x_ok = (r_cx != '0);
            w_nx   = r_cx - c_one;
        end
        if (w_sy == 2'b01) begin
            w_y_ok = (r_cy < c_last);
            w_ny   = r_cy + c_one;
        end else if (w_sy == 2'b11) begin
            w_y_ok = (r_cy != '0);
            w_ny   = r_cy - c_one;
        end
        w_match = w_x_ok && w_y_ok && (probe_cell == color_cell(r_color));
    end

    always_comb begin
        w_state = r_state;
        w_dir   = r_dir;
        w_cx    = r_cx;
        w_cy    = r_cy;
        w_count = r_count;
        w_win   = r_win;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state = ST_FWD;
                    w_dir   = '0;
                    w_cx    = start_x;
                    w_cy    = start_y;
                    w_count = c_inc;
                    w_win   = 1'b0;
                end
            end
            ST_FWD, ST_BWD: begin
                if (w_match) begin
                    w_count = r_count + c_inc;
                    w_cx    = w_nx;
                    w_cy    = w_ny;
                    if (r_count + c_inc == c_win) begin
                        w_state = ST_DONE;
                        w_win   = 1'b1;
                    end
                end else if (r_state == ST_FWD) begin
                    w_state = ST_BWD;
                    w_cx    = r_px;
                    w_cy    = r_py;
                end else begin
                    w_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_dir == 2'd3) begin
                    w_state = ST_DONE;
                end else begin
                    w_state = ST_FWD;
                    w_dir   = r_dir + 2'd1;
                    w_cx    = r_px;
                    w_cy    = r_py;
                    w_count = c_inc;
                end
            end
            ST_DONE: w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge res_n) begin
        if (!res_n) begin
            r_state <= ST_IDLE;
            r_dir   <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_color <= 1'b0;
            r_count <= '0;
            r_win   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_dir   <= w_dir;
            r_cx    <= w_cx;
            r_cy    <= w_cy;
            r_count <= w_count;
            r_win   <= w_win;
            if (r_state == ST_IDLE && start) begin
                r_px    <= start_x;
                r_py    <= start_y;
                r_color <= start_color;
            end
        end
    end

    assign probe_x   = w_nx;
    assign probe_y   = w_ny;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign win       = r_win;
    assign win_color = r_color;

endmodule
`default_nettype wire

// File: rtl/gomoku_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gomoku_core : board, cursor, turn and game status for a two-player gomoku  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gomoku_core
    import gomoku_pkg::*;
#(
    parameter int BOARD_N = 15,
    parameter int WIN_LEN = 5,
    parameter int COORD_W = 4
) (
    input  logic                                  clk_50MHz,
    input  logic                                  res_n,
    gomoku_if.slave                               cmd_bus,
    output logic [COORD_W-1:0]                    cur_x,
    output logic [COORD_W-1:0]                    cur_y,
    output logic                                  turn,
    input  logic [COORD_W-1:0]                    rd_x,
    input  logic [COORD_W-1:0]                    rd_y,
    output logic [1:0]                            rd_cell,
    output logic                                  busy,
    output logic                                  reject,
    output logic                                  game_over,
    output logic                                  winner,
    output logic                                  draw,
    output logic [$clog2(BOARD_N*BOARD_N+1)-1:0]  move_count
);

    localparam int                 c_cells = BOARD_N * BOARD_N;
    localparam int                 c_aw    = $clog2(c_cells);
    localparam int                 c_mw    = $clog2(c_cells + 1);
    localparam logic [COORD_W-1:0] c_last  = COORD_W'(BOARD_N - 1);
    localparam logic [COORD_W-1:0] c_one   = COORD_W'(1);
    localparam logic [COORD_W:0]   c_n     = (COORD_W+1)'(BOARD_N);
    localparam logic [c_mw-1:0]    c_full  = c_mw'(c_cells);

    function automatic logic [c_aw-1:0] cell_idx(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return c_aw'(int'(y) * BOARD_N + int'(x));
    endfunction

    function automatic logic in_board(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return ({1'b0, x} < c_n) && ({1'b0, y} < c_n);
    endfunction

    logic [1:0]         r_board [c_cells];
    logic [COORD_W-1:0] r_cur_x, r_cur_y;
    logic               r_turn, r_reject, r_game_over, r_winner, r_draw;
    logic [c_mw-1:0]    r_move_count;
    logic [1:0]         r_rd_cell;

    logic               w_busy, w_accept, w_active, w_new_game, w_place_try, w_place, w_reject;
    logic [1:0]         w_cur_cell, w_probe_cell;
    logic [COORD_W-1:0] w_probe_x, w_probe_y;
    logic               w_scan_done, w_scan_win, w_scan_color;

    assign w_accept     = cmd_bus.cmd_valid && !w_busy;
    assign w_active     = w_accept && !r_game_over;
    assign w_new_game   = w_accept && (cmd_bus.cmd == c_cmd_new_game);
    assign w_place_try  = w_active && (cmd_bus.cmd == c_cmd_place);
    assign w_cur_cell   = r_board[cell_idx(r_cur_x, r_cur_y)];
    assign w_place      = w_place_try && (w_cur_cell == c_cell_empty);
    assign w_reject     = w_place_try && (w_cur_cell != c_cell_empty);
    assign w_probe_cell = in_board(w_probe_x, w_probe_y) ? r_board[cell_idx(w_probe_x, w_probe_y)] : c_cell_empty;

    gomoku_win_scan #(
        .BOARD_N (BOARD_N),
        .WIN_LEN (WIN_LEN),
        .COORD_W (COORD_W)
    ) u_win_scan (
        .clk_50MHz   (clk_50MHz),
        .res_n       (res_n),
        .start       (w_place),
        .start_x     (r_cur_x),
        .start_y     (r_cur_y),
        .start_color (r_turn),
        .probe_x     (w_probe_x),
        .probe_y     (w_probe_y),
        .probe_cell  (w_probe_cell),
        .busy        (w_busy),
        .done        (w_scan_done),
        .win         (w_scan_win),
        .win_color   (w_scan_color)
    );

    always_ff @(posedge clk_50MHz or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < c_cells; i++) r_board[i] <= c_cell_empty;
        end else if (w_new_game) begin
            for (int i = 0; i < c_cells; i++) r_board[i] <= c_cell_empty;
        end else if (w_place) begin
            r_board[cell_idx(r_cur_x, r_cur_y)] <= color_cell(r_turn);
        end
    end

    always_ff @(posedge clk_50MHz or negedge res_n) begin
        if (!res_n) begin
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_turn       <= 1'b0;
            r_reject     <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
            r_draw       <= 1'b0;
            r_move_count <= '0;
            r_rd_cell    <= c_cell_empty;
        end else begin
            r_reject  <= w_reject;
            // Pre-edge array contents: a same-cycle write is not yet visible
            r_rd_cell <= in_board(rd_x, rd_y) ? r_board[cell_idx(rd_x, rd_y)] : c_cell_empty;
            if (w_new_game) begin
                r_cur_x      <= '0;
                r_cur_y      <= '0;
                r_turn       <= 1'b0;
                r_game_over  <= 1'b0;
                r_winner     <= 1'b0;
                r_draw       <= 1'b0;
                r_move_count <= '0;
            end else begin
                if (w_active) begin
                    case (cmd_bus.cmd)
                        c_cmd_up:    r_cur_y <= (r_cur_y == '0)     ? c_last : r_cur_y - c_one;
                        c_cmd_down:  r_cur_y <= (r_cur_y == c_last) ? '0     : r_cur_y + c_one;
                        c_cmd_left:  r_cur_x <= (r_cur_x == '0)     ? c_last : r_cur_x - c_one;
                        c_cmd_right: r_cur_x <= (r_cur_x == c_last) ? '0     : r_cur_x + c_one;
                        default: ;
                    endcase
                end
                if (w_place) begin
                    r_move_count <= r_move_count + c_mw'(1);
                    r_turn       <= ~r_turn;
                end
                if (w_scan_done) begin
                    if (w_scan_win) begin
                        r_game_over <= 1'b1;
                        r_winner    <= w_scan_color;
                    end else if (r_move_count == c_full) begin
                        r_game_over <= 1'b1;
                        r_draw      <= 1'b1;
                    end
                end
            end
        end
    end

    assign cmd_bus.cmd_ready = !w_busy;
    assign busy              = w_busy;
    assign cur_x             = r_cur_x;
    assign cur_y             = r_cur_y;
    assign turn              = r_turn;
    assign reject            = r_reject;
    assign game_over         = r_game_over;
    assign winner            = r_winner;
    assign draw              = r_draw;
    assign move_count        = r_move_count;
    assign rd_cell           = r_rd_cell;

endmodule
`default_nettype wire

// File: tb/tb_gomoku_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gomoku_core : random and directed games against a line-counting model   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_gomoku_core;
    import gomoku_pkg::*;

    logic clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    logic       res_n;
    logic       drv_valid;
    logic [2:0] drv_cmd;
    logic [3:0] drv_rx, drv_ry;
    int         sel;

    gomoku_if bus_a ();
    gomoku_if bus_b ();

    assign bus_a.cmd_valid = drv_valid && (sel == 0);
    assign bus_a.cmd       = drv_cmd;
    assign bus_b.cmd_valid = drv_valid && (sel == 1);
    assign bus_b.cmd       = drv_cmd;

    logic [3:0] a_cx, a_cy, b_cx, b_cy;
    logic [1:0] a_rd, b_rd;
    logic       a_turn, a_busy, a_rej, a_over, a_win, a_draw;
    logic       b_turn, b_busy, b_rej, b_over, b_win, b_draw;
    logic [7:0] a_mc;
    logic [3:0] b_mc;

    gomoku_core #(.BOARD_N(15), .WIN_LEN(5), .COORD_W(4)) u_dut_a (
        .clk_50MHz (clk_50MHz), .res_n (res_n), .cmd_bus (bus_a),
        .cur_x (a_cx), .cur_y (a_cy), .turn (a_turn), .rd_x (drv_rx), .rd_y (drv_ry),
        .rd_cell (a_rd), .busy (a_busy), .reject (a_rej), .game_over (a_over),
        .winner (a_win), .draw (a_draw), .move_count (a_mc)
    );

    gomoku_core #(.BOARD_N(3), .WIN_LEN(3), .COORD_W(4)) u_dut_b (
        .clk_50MHz (clk_50MHz), .res_n (res_n), .cmd_bus (bus_b),
        .cur_x (b_cx), .cur_y (b_cy), .turn (b_turn), .rd_x (drv_rx), .rd_y (drv_ry),
        .rd_cell (b_rd), .busy (b_busy), .reject (b_rej), .game_over (b_over),
        .winner (b_win), .draw (b_draw), .move_count (b_mc)
    );

    wire [3:0] w_cx    = (sel == 1) ? b_cx   : a_cx;
    wire [3:0] w_cy    = (sel == 1) ? b_cy   : a_cy;
    wire [1:0] w_rd    = (sel == 1) ? b_rd   : a_rd;
    wire       w_turn  = (sel == 1) ? b_turn : a_turn;
    wire       w_busy  = (sel == 1) ? b_busy : a_busy;
    wire       w_rej   = (sel == 1) ? b_rej  : a_rej;
    wire       w_over  = (sel == 1) ? b_over : a_over;
    wire       w_win   = (sel == 1) ? b_win  : a_win;
    wire       w_draw  = (sel == 1) ? b_draw : a_draw;
    wire [7:0] w_mc    = (sel == 1) ? {4'b0, b_mc} : a_mc;
    wire       w_ready = (sel == 1) ? bus_b.cmd_ready : bus_a.cmd_ready;

    // Reference game state: mb[x][y] holds 0 empty, 1 black, 2 white
    int mn, mw;
    int mb [16][16];
    int mcx, mcy, mturn, mcount, mover, mwin, mdraw;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) mb[x][y] = 0;
        mcx = 0; mcy = 0; mturn = 0; mcount = 0; mover = 0; mwin = 0; mdraw = 0;
    endtask

    function automatic int run_len(int x, int y, int dx, int dy, int col);
        int n, cx, cy;
        n = 0; cx = x + dx; cy = y + dy;
        while (cx >= 0 && cx < mn && cy >= 0 && cy < mn && mb[cx][cy] == col) begin
            n++; cx += dx; cy += dy;
        end
        return n;
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_cur_x"}, w_cx, mcx);
        chk({tag, "_cur_y"}, w_cy, mcy);
        chk({tag, "_turn"}, w_turn, mturn);
        chk({tag, "_move_count"}, w_mc, mcount);
        chk({tag, "_game_over"}, w_over, mover);
        chk({tag, "_winner"}, w_win, mwin);
        chk({tag, "_draw"}, w_draw, mdraw);
    endtask

    task automatic send(input logic [2:0] c);
        int n, exp_rej, placed, col, run;
        int dxs [4] = '{1, 0, 1, 1};
        int dys [4] = '{0, 1, 1, -1};
        @(negedge clk_50MHz);
        drv_valid = 1'b1;
        drv_cmd   = c;
        n = 0;
        while (!w_ready && n < 100) begin
            @(negedge clk_50MHz);
            n++;
        end
        chk("cmd_ready", w_ready, 1);
        @(posedge clk_50MHz);
        #1;
        drv_valid = 1'b0;
        exp_rej = 0;
        placed  = 0;
        if (c == c_cmd_new_game) begin
            model_clear();
        end else if (mover == 0) begin
            case (c)
                c_cmd_up:    mcy = (mcy == 0) ? mn - 1 : mcy - 1;
                c_cmd_down:  mcy = (mcy == mn - 1) ? 0 : mcy + 1;
                c_cmd_left:  mcx = (mcx == 0) ? mn - 1 : mcx - 1;
                c_cmd_right: mcx = (mcx == mn - 1) ? 0 : mcx + 1;
                c_cmd_place: begin
                    if (mb[mcx][mcy] != 0) begin
                        exp_rej = 1;
                    end else begin
                        col = mturn + 1;
                        mb[mcx][mcy] = col;
                        mcount++;
                        placed = 1;
                        for (int d = 0; d < 4; d++) begin
                            run = 1 + run_len(mcx, mcy, dxs[d], dys[d], col)
                                    + run_len(mcx, mcy, -dxs[d], -dys[d], col);
                            if (run >= mw) begin mover = 1; mwin = mturn; end
                        end
                        if (mover == 0 && mcount == mn * mn) begin mover = 1; mdraw = 1; end
                        mturn = 1 - mturn;
                    end
                end
                default: ;
            endcase
        end
        chk("reject", w_rej, exp_rej);
        chk("busy_after_cmd", w_busy, placed);
        if (placed != 0) begin
            n = 0;
            while (w_busy && n < 200) begin
                @(posedge clk_50MHz);
                #1;
                n++;
            end
            chk("scan_within_bound", int'((n + 1) <= 8 * (mw - 1) + 5), 1);
        end else if (exp_rej != 0) begin
            @(posedge clk_50MHz);
            #1;
            chk("reject_one_cycle", w_rej, 0);
        end
        check_status("cmd");
    endtask

    task automatic rd_chk(input int x, input int y);
        int exp;
        @(negedge clk_50MHz);
        drv_rx = 4'(x);
        drv_ry = 4'(y);
        @(posedge clk_50MHz);
        #1;
        exp = (x < mn && y < mn) ? mb[x][y] : 0;
        chk("rd_cell", w_rd, exp);
    endtask

    task automatic goto_xy(input int x, input int y);
        for (int i = 0; i < 16 && mcx != x; i++) send(c_cmd_right);
        for (int i = 0; i < 16 && mcy != y; i++) send(c_cmd_down);
    endtask

    task automatic place_at(input int x, input int y);
        goto_xy(x, y);
        send(c_cmd_place);
    endtask

    task automatic select_dut(input int s);
        sel = s;
        mn  = (s == 1) ? 3 : 15;
        mw  = (s == 1) ? 3 : 5;
        send(c_cmd_new_game);
    endtask

    task automatic random_run(input int count);
        int r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 99);
            if (mover != 0 && r < 30)   send(c_cmd_new_game);
            else if (r < 40)            send(c_cmd_place);
            else if (r < 85)            send(3'($urandom_range(0, 3)));
            else if (r < 90)            send(3'($urandom_range(6, 7)));
            else if (r < 92)            send(c_cmd_new_game);
            else                        rd_chk($urandom_range(0, 15), $urandom_range(0, 15));
        end
    endtask

    int seq41 [18] = '{0,7, 0,0, 1,7, 1,0, 2,7, 2,0, 3,7, 3,0, 4,7};
    int seq44 [20] = '{0,14, 12,2, 2,14, 14,0, 4,14, 10,4, 6,14, 13,1, 8,14, 11,3};
    int seq45 [18] = '{0,0, 1,0, 2,0, 1,1, 0,1, 2,1, 1,2, 0,2, 2,2};

    initial begin
        res_n = 1'b0; drv_valid = 1'b0; drv_cmd = 3'd6; drv_rx = '0; drv_ry = '0;
        sel = 0; mn = 15; mw = 5;
        model_clear();
        repeat (3) @(negedge clk_50MHz);
        chk("rst_busy", w_busy, 0);
        chk("rst_reject", w_rej, 0);
        chk("rst_rd_cell", w_rd, 0);
        check_status("rst");
        res_n = 1'b1;
        chk("rst_release_ready", w_ready, 1);

        // Cursor wrap from the origin
        send(c_cmd_up);
        send(c_cmd_left);
        chk("wrap_xy", {28'd0, w_cx} * 16 + {28'd0, w_cy}, 14 * 16 + 14);
        send(c_cmd_right);

        // Double PLACE on one cell
        send(c_cmd_new_game);
        place_at(3, 3);
        send(c_cmd_place);
        chk("dup_move_count", w_mc, 1);
        chk("dup_turn", w_turn, 1);

        // Horizontal black five
        send(c_cmd_new_game);
        for (int i = 0; i < 9; i++) place_at(seq41[2*i], seq41[2*i+1]);
        chk("row_win_over", w_over, 1);
        chk("row_win_winner", w_win, 0);
        rd_chk(4, 7);
        rd_chk(3, 0);
        rd_chk(5, 7);

        // Anti-diagonal white five, stones placed out of order
        send(c_cmd_new_game);
        for (int i = 0; i < 10; i++) place_at(seq44[2*i], seq44[2*i+1]);
        chk("anti_win_winner", w_win, 1);
        send(c_cmd_place);
        send(c_cmd_right);
        send(c_cmd_place);
        chk("anti_frozen_count", w_mc, 10);
        rd_chk(11, 3);

        // Asynchronous reset in the middle of a scan
        send(c_cmd_new_game);
        place_at(7, 7);
        send(c_cmd_right);
        @(negedge clk_50MHz);
        drv_valid = 1'b1;
        drv_cmd   = c_cmd_place;
        @(posedge clk_50MHz);
        #1;
        drv_valid = 1'b0;
        chk("busy_before_reset", w_busy, 1);
        @(posedge clk_50MHz);
        #2;
        res_n = 1'b0;
        #1;
        model_clear();
        chk("midscan_rst_busy", w_busy, 0);
        check_status("midscan_rst");
        @(negedge clk_50MHz);
        res_n = 1'b1;
        chk("midscan_release_ready", w_ready, 1);
        for (int x = 0; x < 15; x++)
            for (int y = 0; y < 15; y++) rd_chk(x, y);
        rd_chk(15, 3);

        random_run(300);

        // Tic-tac-toe draw on the small board
        select_dut(1);
        for (int i = 0; i < 9; i++) place_at(seq45[2*i], seq45[2*i+1]);
        chk("ttt_draw", w_draw, 1);
        chk("ttt_count", w_mc, 9);
        chk("ttt_no_winner", w_win, 0);
        send(c_cmd_new_game);
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++) rd_chk(x, y);

        random_run(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
